// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, latched mode bits
// and the width rule for the slave-select index port.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, PAUSE} state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic cont;
  } spi_mode_t;

  function automatic int ss_idx_width(input int ss_width);
    return (ss_width > 1) ? $clog2(ss_width) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: emits a one-cycle tick every
// load_val+1 cycles, restarted on each FSM state entry.
module spi_clk_gen #(
  parameter int div_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 reload,
  input  logic [div_width-1:0] load_val,
  output logic                 tick
);

  logic [div_width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (hold || reload || (cnt_q == '0)) begin
      cnt_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !hold && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI master with runtime CPOL/CPHA, bit order and SCLK divider, one-hot
// active-low slave selects and a continuous (SS-held) multi-word mode.
module spi_controller
  import spi_pkg::*;
#(
  parameter int word_width = 8,
  parameter int SS_width   = 1,
  parameter int div_width  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [word_width-1:0]               data_in,
  input  logic [ss_idx_width(SS_width)-1:0]   ss_index,
  input  logic                                cpol,
  input  logic                                cpha,
  input  logic                                lsb_first,
  input  logic                                cont,
  // 'release' is a reserved word in SystemVerilog
  input  logic                                release_req,
  input  logic [div_width-1:0]                clk_div,
  output logic                                busy,
  output logic                                done,
  output logic [word_width-1:0]               data_out,
  output logic                                SCLK,
  output logic                                MOSI,
  input  logic                                MISO,
  output logic [SS_width-1:0]                 SS
);

  localparam int IW = ss_idx_width(SS_width);
  localparam int EW = $clog2(2 * word_width + 1);

  state_t                state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [div_width-1:0]  div_q, div_d;
  logic [word_width-1:0] tx_q, tx_d;
  logic [word_width-1:0] rx_q, rx_d;
  logic [word_width-1:0] dout_q, dout_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SS_width-1:0]   ss_q, ss_d;
  logic [SS_width-1:0]   ss_decode;
  logic                  tick;
  logic                  accept;
  logic                  last_edge;
  logic                  sample_edge;

  // Out-of-range indices decode to no selected slave.
  for (genvar gi = 0; gi < SS_width; gi++) begin : g_ss
    assign ss_decode[gi] = (ss_index != IW'(gi));
  end

  // The done cycle is excluded so a start there is not mistaken for a new word.
  assign accept      = start && !busy_q && !done_q && ((state_q == IDLE) || (state_q == PAUSE));
  assign last_edge   = (edge_q == EW'(2 * word_width - 1));
  assign sample_edge = (edge_q[0] == mode_q.cpha);

  spi_clk_gen #(.div_width(div_width)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .hold     ((state_q == IDLE) || (state_q == PAUSE)),
    .reload   (state_d != state_q),
    .load_val (div_d),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (tick) state_d = XFER;
      XFER:  if (tick && last_edge) state_d = HOLD;
      HOLD:  if (tick) state_d = mode_q.cont ? PAUSE : IDLE;
      PAUSE: begin
        if (accept) begin
          state_d = XFER;
        end else if (release_req && !done_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    dout_d = dout_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ss_d   = ss_q;

    if (accept) begin
      mode_d.cpha      = cpha;
      mode_d.lsb_first = lsb_first;
      mode_d.cont      = cont;
      busy_d           = 1'b1;
      edge_d           = '0;
      tx_d             = data_in;
      if (state_q == IDLE) begin
        mode_d.cpol = cpol;
        div_d       = clk_div;
        sclk_d      = cpol;
        ss_d        = ss_decode;
      end
      // With cpha=0 the first bit must be on the line before the first edge.
      if (!cpha) begin
        mosi_d = lsb_first ? data_in[0] : data_in[word_width-1];
        tx_d   = lsb_first ? (data_in >> 1) : (data_in << 1);
      end
    end

    if ((state_q == XFER) && tick) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
      if (sample_edge) begin
        if (mode_q.lsb_first) begin
          rx_d = {MISO, rx_q[word_width-1:1]};
        end else begin
          rx_d = {rx_q[word_width-2:0], MISO};
        end
      end else if (!last_edge) begin
        mosi_d = mode_q.lsb_first ? tx_q[0] : tx_q[word_width-1];
        tx_d   = mode_q.lsb_first ? (tx_q >> 1) : (tx_q << 1);
      end
    end

    if ((state_q == HOLD) && tick) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      dout_d = rx_q;
      if (!mode_q.cont) begin
        ss_d = '1;
      end
    end

    if ((state_q == PAUSE) && !accept && release_req && !done_q) begin
      ss_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      div_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      dout_q <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ss_q   <= '1;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      dout_q <= dout_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ss_q   <= ss_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SS       = ss_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a timeline model derives SCLK/MOSI/SS/busy/done
// per cycle from transfer parameters; a second instance covers ss_index out of range.
module tb_spi_controller;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst, start, cpol, cpha, lsb_first, cont, release_req, miso_one;
  logic [7:0] data_in, clk_div;
  logic [1:0] ss_index;
  logic [2:0] ss_index5;
  logic       miso;

  logic       busy, done, sclk, mosi;
  logic [7:0] data_out;
  logic [3:0] ss;
  logic       busy5, done5, sclk5, mosi5;
  logic [7:0] data_out5;
  logic [4:0] ss5;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // model state
  int         t0 = 0;
  int         m_phase = 0;   // 0 idle, 1 transferring, 2 paused
  int         m_setup = 0;
  int         m_h = 1;
  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0, m_cont = 1'b0;
  logic [7:0] m_data = '0, m_rx = '0, m_dout = '0;
  logic [3:0] m_ss_sel = 4'hF;

  assign miso = miso_one ? 1'b1 : mosi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller #(.word_width(8), .SS_width(4), .div_width(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ss_index(ss_index),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cont(cont),
    .release_req(release_req), .clk_div(clk_div), .busy(busy), .done(done),
    .data_out(data_out), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS(ss)
  );

  spi_controller #(.word_width(8), .SS_width(5), .div_width(8)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ss_index(ss_index5),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cont(cont),
    .release_req(release_req), .clk_div(clk_div), .busy(busy5), .done(done5),
    .data_out(data_out5), .SCLK(sclk5), .MOSI(mosi5), .MISO(miso), .SS(ss5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the timeline of the current transfer.
  always @(posedge clk) begin
    int off, x, e, bi, m_end;
    logic sclk_e, busy_e, done_e;
    logic [3:0] ss_e;
    #1;
    off    = cyc - t0;
    sclk_e = m_cpol;
    busy_e = 1'b0;
    done_e = 1'b0;
    ss_e   = (m_phase == 2) ? m_ss_sel : 4'hF;
    if (m_phase == 1) begin
      m_end  = m_setup + (2 * N + 1) * m_h;
      x      = off - m_setup;
      e      = (x < 0) ? 0 : x / m_h;
      if (e > 2 * N) e = 2 * N;
      sclk_e = m_cpol ^ e[0];
      busy_e = (off < m_end);
      ss_e   = m_ss_sel;
      if (!m_cpha || e >= 1) begin
        bi = m_cpha ? (e - 1) / 2 : e / 2;
        if (bi > N - 1) bi = N - 1;
        chk("mosi", {31'd0, mosi}, {31'd0, m_lsb ? m_data[bi] : m_data[N-1-bi]});
      end
      if (off == m_end) begin
        done_e = 1'b1;
        m_dout = m_rx;
        if (!m_cont) ss_e = 4'hF;
        m_phase = m_cont ? 2 : 0;
      end
    end
    chk("sclk", {31'd0, sclk}, {31'd0, sclk_e});
    chk("busy", {31'd0, busy}, {31'd0, busy_e});
    chk("done", {31'd0, done}, {31'd0, done_e});
    chk("ss", {28'd0, ss}, {28'd0, ss_e});
    chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
    chk("sclk5", {31'd0, sclk5}, {31'd0, sclk_e});
    chk("busy5", {31'd0, busy5}, {31'd0, busy_e});
    chk("done5", {31'd0, done5}, {31'd0, done_e});
    chk("ss5", {27'd0, ss5}, 32'h1F);
    chk("data_out5", {24'd0, data_out5}, {24'd0, m_dout});
  end

  task automatic start_xfer(input logic [7:0] d, input logic pol, input logic ph,
                            input logic lsb, input logic cn, input logic [7:0] div,
                            input logic [1:0] idx, input logic one);
    @(negedge clk);
    data_in = d; cpol = pol; cpha = ph; lsb_first = lsb; cont = cn;
    clk_div = div; ss_index = idx; miso_one = one; start = 1'b1;
    t0 = cyc + 1;
    if (m_phase == 0) begin
      m_cpol   = pol;
      m_h      = int'(div) + 1;
      m_setup  = m_h;
      m_ss_sel = ~(4'b0001 << idx);
    end else begin
      m_setup = 0;
    end
    m_cpha = ph; m_lsb = lsb; m_cont = cn; m_data = d;
    m_rx   = one ? 8'hFF : d;
    m_phase = 1;
  endtask

  task automatic run_xfer(input logic [7:0] d, input logic pol, input logic ph,
                          input logic lsb, input logic cn, input logic [7:0] div,
                          input logic [1:0] idx, input logic one, input logic disturb,
                          output int lat);
    bit got;
    start_xfer(d, pol, ph, lsb, cn, div, idx, one);
    lat = 0;
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) begin
        got = 1;
      end else begin
        @(negedge clk);
        start = 1'b0;
        if (disturb && lat == 6) begin
          start = 1'b1; data_in = ~d; cpol = ~pol; cpha = ~ph; lsb_first = ~lsb;
          cont = 1'b1; clk_div = 8'd7; ss_index = idx + 2'd1;
        end
      end
    end
    if (!got) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required one", lat);
    end
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      start = 1'b1;
      data_in = 8'h3C;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cont = 1'b0;
    release_req = 1'b0; miso_one = 1'b0; data_in = '0; clk_div = '0; ss_index = '0;
    ss_index5 = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_ss", {28'd0, ss}, 32'hF);
    chk("rst_data_out", {24'd0, data_out}, 32'h0);
    chk("rst_mosi", {31'd0, mosi}, 32'h0);
    chk("rst_sclk", {31'd0, sclk}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // mode 0, loopback, with start/data disturbance mid-transfer and in the done cycle
    run_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1, lat);
    chk("m0_latency", lat, 32'd19);
    chk("m0_data_out", {24'd0, data_out}, 32'hA5);
    repeat (2) @(negedge clk);

    // mode 3, H=3, MISO tied high, LSB first
    run_xfer(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 2'd1, 1'b1, 1'b0, lat);
    chk("m3_latency", lat, 32'd55);
    chk("m3_data_out", {24'd0, data_out}, 32'hFF);
    chk("m3_sclk_idle", {31'd0, sclk}, 32'h1);
    chk("m3_ss5_idle", {27'd0, ss5}, 32'h1F);

    // continuous: two words on slave 2, then release
    run_xfer(8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 2'd2, 1'b0, 1'b0, lat);
    chk("cont1_latency", lat, 32'd37);
    chk("cont1_data_out", {24'd0, data_out}, 32'h12);
    chk("cont1_ss_held", {28'd0, ss}, 32'hB);
    run_xfer(8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 2'd0, 1'b0, 1'b0, lat);
    chk("cont2_latency", lat, 32'd35);
    chk("cont2_data_out", {24'd0, data_out}, 32'h34);
    chk("cont2_ss_held", {28'd0, ss}, 32'hB);
    @(negedge clk);
    release_req = 1'b1;
    @(posedge clk);
    m_phase = 0;
    #1 chk("release_ss", {28'd0, ss}, 32'hF);
    @(negedge clk);
    release_req = 1'b0;
    repeat (2) @(negedge clk);

    // reset landing on XFER edge 5 (mode 2, H=2)
    start_xfer(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + m_setup + 5 * m_h - 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    m_phase = 0;
    m_cpol  = 1'b0;
    m_dout  = '0;
    #1;
    chk("rst_mid_ss", {28'd0, ss}, 32'hF);
    chk("rst_mid_sclk", {31'd0, sclk}, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // recovery after reset: mode 1, slave 3
    run_xfer(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd3, 1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 32'd19);
    chk("post_rst_data_out", {24'd0, data_out}, 32'hC3);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
